// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits in front of the dispatcher. It reads
//   32-bit words from the unified RAM over a req/ack port and splits each word
//   into two 16-bit instructions. The instructions go into a small prefetch
//   queue and leave through a valid/ready handshake, each tagged with its PC.
//   A jump redirect flushes the queue and restarts fetch at the jump target.
//
// Parameters
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_run          1 = new fetch requests allowed (the queue drains either way)
//   i_redirect     jump taken: flush and restart fetch at i_redirect_pc
//   i_redirect_pc  jump target (bit 0 is ignored)
//   o_mem_req      read request to the unified RAM
//   o_mem_addr     word address of the request, held stable while o_mem_req=1
//   i_mem_ack      one-cycle acknowledge, i_mem_data valid in the same cycle
//   i_mem_data     [15:0] = halfword at addr+0, [31:16] = halfword at addr+2
//   o_ir_valid     queue head is valid
//   o_ir           instruction at the queue head
//   o_ir_pc        PC of o_ir
//   i_ir_ready     consumer pops the head when o_ir_valid & i_ir_ready
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_ir_valid,
  output logic [15:0] o_ir,
  output logic [31:0] o_ir_pc,
  input  logic        i_ir_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE : no request outstanding
  // REQ  : request outstanding, its data will be queued
  // DRAIN: request outstanding but a redirect arrived, its data is dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [31:0]    fpc;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic [15:0]    instr_q [DEPTH];
  logic [31:0]    pc_q    [DEPTH];

  logic           start_req;
  logic           accept;
  logic           push_two;
  logic           push_one;
  logic           pop;
  logic [CW-1:0]  n_push;

  // Bit 0 of every PC is always zero, so these bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_redirect_pc[0], fpc[0]};

  // ---------------------------------------------------------------------------
  // Next-state logic and the per-cycle push/pop decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt = state;
    start_req = 1'b0;
    accept    = 1'b0;

    case (state)
      IDLE: begin
        // Issue only with two free entries: a word can carry two instructions.
        if (i_run && !i_redirect && (count <= CW'(DEPTH - 2))) begin
          state_nxt = REQ;
          start_req = 1'b1;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          // A same-cycle redirect still ends the transaction, but drops the data.
          state_nxt = IDLE;
          accept    = !i_redirect;
        end else if (i_redirect) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (i_mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // An odd-halfword fetch address means only the upper halfword is wanted.
    push_two = accept && !fpc[1];
    push_one = accept &&  fpc[1];
    n_push   = push_two ? CW'(2) : (push_one ? CW'(1) : '0);

    // Redirect wins over a same-cycle pop.
    pop      = o_ir_valid && i_ir_ready && !i_redirect;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Fetch PC, request address and prefetch queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fpc        <= {RESET_PC[31:1], 1'b0};
      o_mem_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      // NOTE: the queue storage is reset because o_ir/o_ir_pc read it directly and must be 0 out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      // The address is captured once per request and never changes until ack.
      if (start_req) o_mem_addr <= {fpc[31:2], 2'b00};

      if (i_redirect) begin
        fpc    <= {i_redirect_pc[31:1], 1'b0};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) fpc <= {fpc[31:2], 2'b00} + 32'd4;

        if (push_two) begin
          instr_q[wr_ptr]           <= i_mem_data[15:0];
          pc_q[wr_ptr]              <= {fpc[31:2], 2'b00};
          instr_q[wr_ptr + PW'(1)]  <= i_mem_data[31:16];
          pc_q[wr_ptr + PW'(1)]     <= {fpc[31:2], 2'b10};
          wr_ptr                    <= wr_ptr + PW'(2);
        end else if (push_one) begin
          instr_q[wr_ptr]           <= i_mem_data[31:16];
          pc_q[wr_ptr]              <= {fpc[31:2], 2'b10};
          wr_ptr                    <= wr_ptr + PW'(1);
        end

        if (pop) rd_ptr <= rd_ptr + PW'(1);

        count <= count + n_push - CW'(pop);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_mem_req  = (state != IDLE);
  assign o_ir_valid = (count != '0);
  assign o_ir       = instr_q[rd_ptr];
  assign o_ir_pc    = pc_q[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A memory responder answers requests
//   from a fixed address->data function with a chosen or random wait; a
//   monitor predicts every popped instruction as "the next halfword of memory
//   after the last redirect target" and compares PC and opcode. Directed
//   sequences cover reset, redirect in each state, the full-queue stall,
//   address wrap and asynchronous reset; a random phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk;
  logic        i_rst;
  logic        i_run;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack  = 1'b0;
  logic [31:0] i_mem_data = 32'h0;
  logic        o_ir_valid;
  logic [15:0] o_ir;
  logic [31:0] o_ir_pc;
  logic        i_ir_ready;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_run        (i_run),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_data   (i_mem_data),
    .o_ir_valid   (o_ir_valid),
    .o_ir         (o_ir),
    .o_ir_pc      (o_ir_pc),
    .i_ir_ready   (i_ir_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: address 0 holds the word the bring-up check expects,
  // every other word is a scrambled function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'hBBBB_AAAA;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder: fixed_delay >= 0 gives that many wait cycles, < 0 random.
  // ---------------------------------------------------------------------------
  int          fixed_delay = 0;
  bit          pending     = 1'b0;
  int          wait_left   = 0;
  logic [31:0] req_addr    = 32'h0;
  int          ack_count   = 0;

  always @(negedge i_clk) begin
    i_mem_ack = 1'b0;
    if (!i_rst) begin
      pending = 1'b0;
    end else if (o_mem_req) begin
      if (!pending) begin
        pending   = 1'b1;
        req_addr  = o_mem_addr;
        wait_left = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
        check("addr_align", {30'd0, o_mem_addr[1:0]}, 32'h0);
      end else begin
        check("addr_stable", o_mem_addr, req_addr);
      end
      if (wait_left == 0) begin
        i_mem_ack  = 1'b1;
        i_mem_data = mem_word(o_mem_addr);
        pending    = 1'b0;
        ack_count++;
      end else begin
        wait_left--;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: instructions leave in strict PC order starting at the
  // last redirect target (or RESET_PC), each equal to that halfword of memory.
  // ---------------------------------------------------------------------------
  logic [31:0] exp_pc    = RESET_PC;
  int          pop_count = 0;

  always @(negedge i_clk) begin
    #2;
    if (!i_rst) begin
      exp_pc = RESET_PC;
    end else begin
      if (o_ir_valid && i_ir_ready && !i_redirect) begin
        check("pop_pc", o_ir_pc, exp_pc);
        check("pop_ir", {16'h0, o_ir}, {16'h0, half_at(exp_pc)});
        exp_pc = exp_pc + 32'd2;
        pop_count++;
      end
      if (i_redirect) exp_pc = {i_redirect_pc[31:1], 1'b0};
    end
  end

  task automatic wait_req(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (o_mem_req) begin
        found = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic wait_valid(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (o_ir_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          found;
    int          base;
    logic [31:0] a;

    i_rst = 1'b0; i_run = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_ir_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_req",   {31'd0, o_mem_req},  32'h0);
    check("rst_addr",  o_mem_addr,          32'h0);
    check("rst_valid", {31'd0, o_ir_valid}, 32'h0);
    check("rst_ir",    {16'h0, o_ir},       32'h0);
    check("rst_ir_pc", o_ir_pc,             32'h0);

    // 1: bring-up fetch from address 0, zero-wait memory
    i_rst = 1'b1; i_run = 1'b1; i_ir_ready = 1'b1;
    wait_valid(20, found);
    check("t1_valid_seen", {31'd0, found}, 32'h1);
    check("t1_ir0",  {16'h0, o_ir}, 32'h0000_AAAA);
    check("t1_pc0",  o_ir_pc,       32'h0);
    @(negedge i_clk);
    check("t1_ir1",  {16'h0, o_ir}, 32'h0000_BBBB);
    check("t1_pc1",  o_ir_pc,       32'h2);
    check("t1_req",  {31'd0, o_mem_req}, 32'h1);
    check("t1_addr", o_mem_addr,    32'h4);
    base = pop_count;
    repeat (40) @(negedge i_clk);
    check("t1_rate", pop_count - base, 32'd40);

    // 2: redirect to an odd halfword while IDLE
    i_run = 1'b0;
    repeat (8) @(negedge i_clk);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0106; i_run = 1'b1;
    @(negedge i_clk);
    i_redirect = 1'b0;
    @(negedge i_clk);
    check("t2_req",   {31'd0, o_mem_req}, 32'h1);
    check("t2_addr",  o_mem_addr, 32'h104);
    @(negedge i_clk);
    check("t2_valid", {31'd0, o_ir_valid}, 32'h1);
    check("t2_pc",    o_ir_pc, 32'h106);
    check("t2_ir",    {16'h0, o_ir}, {16'h0, half_at(32'h106)});
    @(negedge i_clk);
    check("t2_next_req",  {31'd0, o_mem_req}, 32'h1);
    check("t2_next_addr", o_mem_addr, 32'h108);

    // 3: redirect while a slow request is outstanding
    i_run = 1'b0;
    repeat (8) @(negedge i_clk);
    fixed_delay = 3; i_run = 1'b1;
    @(negedge i_clk);
    wait_req(10, found);
    check("t3_req_seen", {31'd0, found}, 32'h1);
    a = o_mem_addr;
    check("t3_addr", a, 32'h10C);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      i_redirect = 1'b0;
      check("t3_drain_req",  {31'd0, o_mem_req}, 32'h1);
      check("t3_drain_addr", o_mem_addr, a);
    end
    @(negedge i_clk);
    check("t3_idle_req",   {31'd0, o_mem_req},  32'h0);
    check("t3_no_queue",   {31'd0, o_ir_valid}, 32'h0);
    @(negedge i_clk);
    check("t3_target_req",  {31'd0, o_mem_req}, 32'h1);
    check("t3_target_addr", o_mem_addr, 32'h200);
    wait_valid(10, found);
    check("t3_valid_seen", {31'd0, found}, 32'h1);
    check("t3_first_pc", o_ir_pc, 32'h200);

    // 4: consumer stalled, queue fills and fetch stops
    i_ir_ready = 1'b0; i_run = 1'b0;
    repeat (8) @(negedge i_clk);
    fixed_delay = 0;
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300; i_run = 1'b1;
    @(negedge i_clk);
    i_redirect = 1'b0;
    base = ack_count;
    repeat (20) @(negedge i_clk);
    check("t4_fetches", ack_count - base, 32'd2);
    check("t4_full_req", {31'd0, o_mem_req}, 32'h0);
    check("t4_head_pc", o_ir_pc, 32'h300);
    i_ir_ready = 1'b1;
    @(negedge i_clk);
    i_ir_ready = 1'b0;
    repeat (10) @(negedge i_clk);
    check("t4_one_pop_req", {31'd0, o_mem_req}, 32'h0);
    check("t4_one_pop_fetches", ack_count - base, 32'd2);
    i_ir_ready = 1'b1; fixed_delay = 2;
    @(negedge i_clk);
    i_ir_ready = 1'b0;
    wait_req(5, found);
    check("t4_two_pop_req", {31'd0, found}, 32'h1);

    // 5: redirect, ack and pop all in the same cycle
    @(negedge i_clk);
    @(negedge i_clk);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0400; i_ir_ready = 1'b1;
    @(negedge i_clk);
    i_redirect = 1'b0; i_ir_ready = 1'b0; fixed_delay = 0;
    check("t5_req_idle", {31'd0, o_mem_req},  32'h0);
    check("t5_empty",    {31'd0, o_ir_valid}, 32'h0);
    @(negedge i_clk);
    check("t5_req",  {31'd0, o_mem_req}, 32'h1);
    check("t5_addr", o_mem_addr, 32'h400);
    @(negedge i_clk);
    check("t5_pc",   o_ir_pc, 32'h400);

    // 6: address wrap, then asynchronous reset in the middle of a request
    i_ir_ready = 1'b1; fixed_delay = 3;
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    @(negedge i_clk);
    i_redirect = 1'b0;
    @(negedge i_clk);
    check("t6_req",  {31'd0, o_mem_req}, 32'h1);
    check("t6_addr", o_mem_addr, 32'hFFFF_FFFC);
    wait_valid(10, found);
    check("t6_valid_seen", {31'd0, found}, 32'h1);
    check("t6_pc", o_ir_pc, 32'hFFFF_FFFC);
    wait_req(10, found);
    check("t6_wrap_seen", {31'd0, found}, 32'h1);
    check("t6_wrap_addr", o_mem_addr, 32'h0);
    #1 i_rst = 1'b0;
    #1;
    check("t6_rst_req",   {31'd0, o_mem_req},  32'h0);
    check("t6_rst_valid", {31'd0, o_ir_valid}, 32'h0);
    check("t6_rst_ir_pc", o_ir_pc, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1; fixed_delay = -1;

    // 7: random traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      @(negedge i_clk);
      i_run         = ($urandom_range(0, 7) != 0);
      i_ir_ready    = ($urandom_range(0, 3) != 0);
      i_redirect    = ($urandom_range(0, 31) == 0);
      i_redirect_pc = $urandom;
    end
    @(negedge i_clk);
    i_redirect = 1'b0; i_run = 1'b1; i_ir_ready = 1'b1;
    repeat (10) @(negedge i_clk);
    base = pop_count;
    repeat (20) @(negedge i_clk);
    check("t7_progress", {31'd0, (pop_count - base) > 0}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
